// File: rtl/period_timer.sv
`default_nettype none
// ============================================================================
//  Module   : period_timer
//  Purpose  : Programmable period timer with up or up/down (center-aligned)
//             counting, free-running or one-shot operation, and a shadowed
//             period register that takes effect only at a wrap event or start.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_clk        in   1      clock, all logic on rising edge
//    i_res        in   1      synchronous active-high reset
//    i_en         in   1      count enable (level)
//    i_start      in   1      strobe: (re)start from 0, latch modes
//    i_stop       in   1      strobe: stop and clear count (wins over start)
//    i_oneshot    in   1      mode latched at start: stop after one period
//    i_center     in   1      mode latched at start: up/down counting
//    i_period     in   WIDTH  new period value
//    i_period_wr  in   1      strobe: write i_period to shadow
//    o_cnt        out  WIDTH  current count
//    o_dir        out  1      0 = up, 1 = down
//    o_tc         out  1      one-cycle terminal-count pulse
//    o_run        out  1      timer running
//    o_pend       out  1      shadow period awaiting transfer
// ============================================================================
module period_timer #(
  parameter int               WIDTH      = 24,
  parameter logic [WIDTH-1:0] RST_PERIOD = {WIDTH{1'b1}}
) (
  input  logic             i_clk,
  input  logic             i_res,
  input  logic             i_en,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_oneshot,
  input  logic             i_center,
  input  logic [WIDTH-1:0] i_period,
  input  logic             i_period_wr,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_dir,
  output logic             o_tc,
  output logic             o_run,
  output logic             o_pend
);

  localparam logic [WIDTH-1:0] C_ZERO = '0;
  localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] r_cnt;
  logic             r_dir;
  logic             r_tc;
  logic             r_run;
  logic             r_pend;
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_shadow;
  logic             r_oneshot;
  logic             r_center;

  logic             w_step;
  logic             w_turn;
  logic             w_down;
  logic             w_wrap;
  logic             w_wrap_evt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_dir_nxt;

  // Next-count datapath. In center mode the step taken at the top (cnt==P)
  // already counts downward, so P=1 wraps directly from 1 to 0 and the
  // period stays 2P. P=0 wraps on every enabled cycle in either mode.
  always_comb begin
    w_step    = r_run & i_en;
    w_turn    = r_center & ~r_dir & (r_cnt == r_period);
    w_down    = r_center & (r_dir | w_turn);
    w_wrap    = 1'b0;
    w_cnt_nxt = r_cnt;
    w_dir_nxt = r_dir;
    if (r_period == C_ZERO) begin
      w_wrap = 1'b1;
    end else if (r_center) begin
      w_wrap = w_down & (r_cnt == C_ONE);
    end else begin
      w_wrap = (r_cnt == r_period);
    end
    if (w_wrap) begin
      w_cnt_nxt = C_ZERO;
      w_dir_nxt = 1'b0;
    end else if (w_down) begin
      w_cnt_nxt = r_cnt - C_ONE;
      w_dir_nxt = 1'b1;
    end else begin
      w_cnt_nxt = r_cnt + C_ONE;
      w_dir_nxt = 1'b0;
    end
    w_wrap_evt = w_step & w_wrap;
  end

  always_ff @(posedge i_clk) begin
    if (i_res) begin
      r_cnt     <= C_ZERO;
      r_dir     <= 1'b0;
      r_tc      <= 1'b0;
      r_run     <= 1'b0;
      r_pend    <= 1'b0;
      r_period  <= RST_PERIOD;
      r_shadow  <= RST_PERIOD;
      r_oneshot <= 1'b0;
      r_center  <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (i_stop) begin
        r_run <= 1'b0;
        r_cnt <= C_ZERO;
        r_dir <= 1'b0;
      end else if (i_start) begin
        // Restart abandons the current period without a tc pulse.
        r_run     <= 1'b1;
        r_cnt     <= C_ZERO;
        r_dir     <= 1'b0;
        r_oneshot <= i_oneshot;
        r_center  <= i_center;
        if (r_pend) begin
          r_period <= r_shadow;
          r_pend   <= 1'b0;
        end
      end else if (w_wrap_evt) begin
        r_cnt <= C_ZERO;
        r_dir <= 1'b0;
        r_tc  <= 1'b1;
        if (r_pend) begin
          r_period <= r_shadow;
          r_pend   <= 1'b0;
        end
        if (r_oneshot) begin
          r_run <= 1'b0;
        end
      end else if (w_step) begin
        r_cnt <= w_cnt_nxt;
        r_dir <= w_dir_nxt;
      end

      // A write issued alongside a transfer: the old shadow has already been
      // consumed above, the new value is kept pending. While idle the count
      // is 0, so loading the active period directly is always safe.
      if (i_period_wr) begin
        r_shadow <= i_period;
        if (r_run) begin
          r_pend <= 1'b1;
        end else begin
          r_period <= i_period;
          r_pend   <= 1'b0;
        end
      end
    end
  end

  assign o_cnt  = r_cnt;
  assign o_dir  = r_dir;
  assign o_tc   = r_tc;
  assign o_run  = r_run;
  assign o_pend = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_period_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_period_timer
//  Purpose  : Directed scoreboard bench for period_timer (WIDTH = 8).
//             Stimulus pushes the expected post-edge outputs; a monitor pops
//             and compares one entry after every rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_period_timer;

  localparam int WIDTH = 8;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] cnt;
    logic             dir;
    logic             tc;
    logic             run;
    logic             pend;
  } exp_t;

  logic             clk = 1'b0;
  logic             res = 1'b1;
  logic             en = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             os = 1'b0;
  logic             ce = 1'b0;
  logic [WIDTH-1:0] per = '0;
  logic             wr = 1'b0;
  logic [WIDTH-1:0] o_cnt;
  logic             o_dir;
  logic             o_tc;
  logic             o_run;
  logic             o_pend;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  period_timer #(.WIDTH(WIDTH)) dut (
    .i_clk       (clk),
    .i_res       (res),
    .i_en        (en),
    .i_start     (start),
    .i_stop      (stop),
    .i_oneshot   (os),
    .i_center    (ce),
    .i_period    (per),
    .i_period_wr (wr),
    .o_cnt       (o_cnt),
    .o_dir       (o_dir),
    .o_tc        (o_tc),
    .o_run       (o_run),
    .o_pend      (o_pend)
  );

  always #5 clk = ~clk;

  // Monitor: one scoreboard entry per rising edge, sampled 1 time unit later.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_tests++;
        if (o_cnt !== e.cnt || o_dir !== e.dir || o_tc !== e.tc ||
            o_run !== e.run || o_pend !== e.pend) begin
          n_fail++;
          $display("FAIL %s: got cnt=%0d dir=%b tc=%b run=%b pend=%b, expected cnt=%0d dir=%b tc=%b run=%b pend=%b",
                   e.name, o_cnt, o_dir, o_tc, o_run, o_pend,
                   e.cnt, e.dir, e.tc, e.run, e.pend);
        end
      end
    end
  end

  // Push the expected outputs after the coming edge, clock once, drop strobes.
  task automatic chk(input string nm, input int c, input logic d, input logic t,
                     input logic r, input logic p);
    exp_t e;
    e.name = nm;
    e.cnt  = WIDTH'(c);
    e.dir  = d;
    e.tc   = t;
    e.run  = r;
    e.pend = p;
    sb.push_back(e);
    @(posedge clk);
    #2;
    start = 1'b0;
    stop  = 1'b0;
    wr    = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not complete, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // Reset and idle behaviour
    chk("reset", 0, 0, 0, 0, 0);
    chk("reset_hold", 0, 0, 0, 0, 0);
    res = 1'b0;
    en  = 1'b1;
    chk("idle", 0, 0, 0, 0, 0);

    // Idle write loads P directly; up count 0..3 with tc after each wrap
    wr = 1'b1; per = 8'd3;
    chk("wr_idle", 0, 0, 0, 0, 0);
    start = 1'b1;
    chk("start", 0, 0, 0, 1, 0);
    for (int n = 0; n < 2; n++) begin
      for (int k = 1; k <= 3; k++) chk("up_p3", k, 0, 0, 1, 0);
      chk("wrap_p3", 0, 0, 1, 1, 0);
    end

    // Running write of 5 at cnt=1: old period finishes, then 0..5
    chk("up_p3", 1, 0, 0, 1, 0);
    wr = 1'b1; per = 8'd5;
    chk("wr_run", 2, 0, 0, 1, 1);
    chk("pend_hold", 3, 0, 0, 1, 1);
    chk("xfer5", 0, 0, 1, 1, 0);
    for (int k = 1; k <= 5; k++) chk("up_p5", k, 0, 0, 1, 0);
    chk("wrap_p5", 0, 0, 1, 1, 0);

    // Back to 3, then a write coincident with the wrap at cnt==3
    wr = 1'b1; per = 8'd3;
    chk("wr3", 1, 0, 0, 1, 1);
    for (int k = 2; k <= 5; k++) chk("p5_pending", k, 0, 0, 1, 1);
    chk("xfer3", 0, 0, 1, 1, 0);
    chk("up_p3b", 1, 0, 0, 1, 0);
    chk("up_p3b", 2, 0, 0, 1, 0);
    chk("up_p3b", 3, 0, 0, 1, 0);
    wr = 1'b1; per = 8'd7;
    chk("wr_at_wrap", 0, 0, 1, 1, 1);
    for (int k = 1; k <= 3; k++) chk("old_p3_kept", k, 0, 0, 1, 1);
    chk("xfer7", 0, 0, 1, 1, 0);
    for (int k = 1; k <= 7; k++) chk("up_p7", k, 0, 0, 1, 0);
    chk("wrap_p7", 0, 0, 1, 1, 0);
    stop = 1'b1;
    chk("stop", 0, 0, 0, 0, 0);

    // Center-aligned, P=3; mode input dropped after start must be ignored
    wr = 1'b1; per = 8'd3;
    chk("wr_idle3", 0, 0, 0, 0, 0);
    start = 1'b1; ce = 1'b1;
    chk("start_ctr", 0, 0, 0, 1, 0);
    ce = 1'b0;
    for (int n = 0; n < 2; n++) begin
      chk("ctr", 1, 0, 0, 1, 0);
      chk("ctr", 2, 0, 0, 1, 0);
      chk("ctr_top", 3, 0, 0, 1, 0);
      chk("ctr_dn", 2, 1, 0, 1, 0);
      chk("ctr_dn", 1, 1, 0, 1, 0);
      chk("ctr_wrap", 0, 0, 1, 1, 0);
    end
    stop = 1'b1;
    chk("stop_ctr", 0, 0, 0, 0, 0);

    // Oneshot, P=2
    wr = 1'b1; per = 8'd2;
    chk("wr_idle2", 0, 0, 0, 0, 0);
    start = 1'b1; os = 1'b1;
    chk("start_os", 0, 0, 0, 1, 0);
    os = 1'b0;
    chk("os", 1, 0, 0, 1, 0);
    chk("os", 2, 0, 0, 1, 0);
    chk("os_end", 0, 0, 1, 0, 0);
    chk("os_hold", 0, 0, 0, 0, 0);
    chk("os_hold", 0, 0, 0, 0, 0);

    // Enable gating at cnt=1, free-run P=2
    start = 1'b1;
    chk("start_fr", 0, 0, 0, 1, 0);
    chk("fr", 1, 0, 0, 1, 0);
    en = 1'b0;
    for (int k = 0; k < 4; k++) chk("en_hold", 1, 0, 0, 1, 0);
    en = 1'b1;
    chk("en_resume", 2, 0, 0, 1, 0);
    chk("fr_wrap", 0, 0, 1, 1, 0);
    chk("fr", 1, 0, 0, 1, 0);
    chk("fr", 2, 0, 0, 1, 0);

    // Reset in the wrap cycle: no tc, P back to 255
    res = 1'b1;
    chk("res_mid", 0, 0, 0, 0, 0);
    res = 1'b0;
    start = 1'b1;
    chk("start_rstp", 0, 0, 0, 1, 0);
    for (int k = 1; k <= 3; k++) chk("rst_period", k, 0, 0, 1, 0);
    start = 1'b1;
    chk("restart", 0, 0, 0, 1, 0);
    chk("restart_up", 1, 0, 0, 1, 0);
    start = 1'b1; stop = 1'b1;
    chk("start_stop", 0, 0, 0, 0, 0);
    chk("idle2", 0, 0, 0, 0, 0);

    // P=0: count stays 0, wrap every enabled cycle
    wr = 1'b1; per = 8'd0;
    chk("wr_p0", 0, 0, 0, 0, 0);
    start = 1'b1;
    chk("start_p0", 0, 0, 0, 1, 0);
    chk("p0_wrap", 0, 0, 1, 1, 0);
    chk("p0_wrap", 0, 0, 1, 1, 0);
    stop = 1'b1;
    chk("stop_p0", 0, 0, 0, 0, 0);

    #10;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
